// File: rtl/v10_peak_detector.sv
// Peak detector for the v10 trapezoidal filter stream: one record per pulse with
// peak amplitude, peak timestamp, pile-up and truncation flags.
module v10_peak_detector #(
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 32,
  parameter int THRESHOLD  = 200,
  parameter int HYST       = 20,
  parameter int DEAD_TIME  = 8,
  parameter int MAX_LEN    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] filter_data,
  output logic                  peak_valid,
  output logic [DATA_WIDTH-1:0] peak_amplitude,
  output logic [TS_WIDTH-1:0]   peak_time,
  output logic                  peak_pileup,
  output logic                  peak_truncated,
  output logic [15:0]           event_count,
  output logic                  busy
);

  localparam int EW        = DATA_WIDTH + 1;
  localparam int END_LEVEL = (THRESHOLD > HYST) ? (THRESHOLD - HYST) : 0;
  localparam int LW        = $clog2(MAX_LEN + 1);
  localparam int DW        = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

  // One extra bit so sample+HYST never wraps, even at full-scale input.
  localparam logic [EW-1:0] THR_E     = EW'(THRESHOLD);
  localparam logic [EW-1:0] HYST_E    = EW'(HYST);
  localparam logic [EW-1:0] END_E     = EW'(END_LEVEL);
  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [DW-1:0] DEAD_LAST = DW'((DEAD_TIME > 0) ? (DEAD_TIME - 1) : 0);

  typedef enum logic [1:0] {IDLE, ACTIVE, DEAD} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [TS_WIDTH-1:0]   r_ts;
  logic [DATA_WIDTH-1:0] r_max;
  logic [TS_WIDTH-1:0]   r_maxTs;
  logic [DATA_WIDTH-1:0] r_minSinceMax;
  logic [LW-1:0]         r_len;
  logic                  r_falling;
  logic                  r_pileup;
  logic [DW-1:0]         r_deadCnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_amp;
  logic [TS_WIDTH-1:0]   r_time;
  logic                  r_pileupOut;
  logic                  r_truncOut;
  logic [15:0]           r_count;

  logic [EW-1:0]         w_x;
  logic                  w_start;
  logic                  w_endHit;
  logic                  w_lenHit;
  logic                  w_emit;
  logic [DATA_WIDTH-1:0] w_maxNext;
  logic [TS_WIDTH-1:0]   w_maxTsNext;
  logic [DATA_WIDTH-1:0] w_minNext;
  logic                  w_fallingNext;
  logic                  w_pileupNext;

  assign w_x      = {1'b0, filter_data};
  assign w_start  = (r_state == IDLE) && (w_x >= THR_E);
  assign w_endHit = (w_x < END_E);
  assign w_lenHit = (r_len == MAX_LEN_L);
  assign w_emit   = (r_state == ACTIVE) && (w_endHit || w_lenHit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_start) w_nextState = ACTIVE;
      ACTIVE:  if (w_emit) w_nextState = (DEAD_TIME > 0) ? DEAD : IDLE;
      DEAD:    if (r_deadCnt == DEAD_LAST) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  // Max, falling and pile-up update in order, each step seeing the previous one's result.
  always_comb begin
    w_maxNext     = r_max;
    w_maxTsNext   = r_maxTs;
    w_minNext     = r_minSinceMax;
    w_fallingNext = r_falling;
    w_pileupNext  = r_pileup;
    if (w_x > {1'b0, r_max}) begin
      w_maxNext   = filter_data;
      w_maxTsNext = r_ts;
      w_minNext   = filter_data;
    end
    if ((w_x + HYST_E) < {1'b0, w_maxNext}) w_fallingNext = 1'b1;
    if (w_fallingNext) begin
      if (filter_data < w_minNext) w_minNext = filter_data;
      if (w_x > ({1'b0, w_minNext} + HYST_E)) w_pileupNext = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ts          <= '0;
      r_max         <= '0;
      r_maxTs       <= '0;
      r_minSinceMax <= '0;
      r_len         <= '0;
      r_falling     <= 1'b0;
      r_pileup      <= 1'b0;
      r_deadCnt     <= '0;
      r_valid       <= 1'b0;
      r_amp         <= '0;
      r_time        <= '0;
      r_pileupOut   <= 1'b0;
      r_truncOut    <= 1'b0;
      r_count       <= '0;
    end else begin
      r_ts    <= r_ts + TS_WIDTH'(1);
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_max         <= filter_data;
            r_maxTs       <= r_ts;
            r_minSinceMax <= filter_data;
            r_len         <= LW'(1);
            r_falling     <= 1'b0;
            r_pileup      <= 1'b0;
          end
        end
        ACTIVE: begin
          if (w_emit) begin
            r_valid     <= 1'b1;
            r_amp       <= r_max;
            r_time      <= r_maxTs;
            r_pileupOut <= r_pileup;
            r_truncOut  <= w_lenHit && !w_endHit;
            r_count     <= r_count + 16'd1;
            r_deadCnt   <= '0;
          end else begin
            r_max         <= w_maxNext;
            r_maxTs       <= w_maxTsNext;
            r_minSinceMax <= w_minNext;
            r_falling     <= w_fallingNext;
            r_pileup      <= w_pileupNext;
            r_len         <= r_len + LW'(1);
          end
        end
        DEAD: begin
          r_deadCnt <= r_deadCnt + DW'(1);
        end
        default: begin
          r_deadCnt <= '0;
        end
      endcase
    end
  end

  assign peak_valid     = r_valid;
  assign peak_amplitude = r_amp;
  assign peak_time      = r_time;
  assign peak_pileup    = r_pileupOut;
  assign peak_truncated = r_truncOut;
  assign event_count    = r_count;

endmodule

// File: tb/tb_v10_peak_detector.sv
// Scoreboard bench for v10_peak_detector: a whole-segment pulse model fills the
// expected-record queue, a negedge monitor pops and compares every strobe.
module tb_v10_peak_detector;

  localparam int THRESHOLD = 200;
  localparam int HYST      = 20;
  localparam int DEAD_TIME = 8;
  localparam int MAX_LEN   = 64;
  localparam int END_LEVEL = (THRESHOLD > HYST) ? (THRESHOLD - HYST) : 0;

  typedef struct {
    int amp;
    int tm;
    int pile;
    int trunc;
    int cnt;
    int emitTs;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] filter_data = '0;
  logic        peak_valid;
  logic [15:0] peak_amplitude;
  logic [31:0] peak_time;
  logic        peak_pileup;
  logic        peak_truncated;
  logic [15:0] event_count;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   tbTs = 0;
  int   stim[$];
  rec_t expQ[$];
  rec_t lastRec;
  int   segRecords;

  v10_peak_detector #(
    .DATA_WIDTH(16), .TS_WIDTH(32), .THRESHOLD(THRESHOLD),
    .HYST(HYST), .DEAD_TIME(DEAD_TIME), .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk), .reset(reset), .filter_data(filter_data),
    .peak_valid(peak_valid), .peak_amplitude(peak_amplitude), .peak_time(peak_time),
    .peak_pileup(peak_pileup), .peak_truncated(peak_truncated),
    .event_count(event_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Timestamp of the current cycle as the detector is meant to see it.
  always @(posedge clk) tbTs <= reset ? 0 : tbTs + 1;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int stimAt(input int k);
    return (k < stim.size()) ? stim[k] : 0;
  endfunction

  // Walks the sample list pulse by pulse; index k of the segment carries ts = k.
  task automatic modelSegment();
    int i, j, x, mx, mxTs, mn, fall, pile, cnt;
    rec_t r;
    i = 0;
    cnt = 0;
    while (i < stim.size()) begin
      if (stimAt(i) >= THRESHOLD) begin
        mx = stimAt(i); mxTs = i; mn = mx; fall = 0; pile = 0;
        j = i + 1;
        while (!(stimAt(j) < END_LEVEL) && (j - i) < MAX_LEN) begin
          x = stimAt(j);
          if (x > mx) begin mx = x; mxTs = j; mn = x; end
          if (x + HYST < mx) fall = 1;
          if (fall != 0) begin
            if (x < mn) mn = x;
            if (x > mn + HYST) pile = 1;
          end
          j++;
        end
        cnt++;
        r.amp = mx; r.tm = mxTs; r.pile = pile;
        r.trunc = ((j - i) == MAX_LEN && !(stimAt(j) < END_LEVEL)) ? 1 : 0;
        r.cnt = cnt % 65536; r.emitTs = j + 1;
        expQ.push_back(r);
        lastRec = r;
        i = j + 1 + DEAD_TIME;
      end else begin
        i++;
      end
    end
    segRecords = cnt;
  endtask

  // Reset (with rstData on the input during the reset cycle), play the segment, drain and check.
  task automatic applyStimulus(input int rstData);
    expQ.delete();
    segRecords = 0;
    modelSegment();
    filter_data = 16'(rstData);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_valid", peak_valid, 0);
    checkOutput("reset_amplitude", peak_amplitude, 0);
    checkOutput("reset_time", peak_time, 0);
    checkOutput("reset_pileup", peak_pileup, 0);
    checkOutput("reset_truncated", peak_truncated, 0);
    checkOutput("reset_event_count", event_count, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b0;
    foreach (stim[k]) begin
      filter_data = 16'(stim[k]);
      @(posedge clk); #1;
    end
    filter_data = '0;
    repeat (DEAD_TIME + 6) @(posedge clk);
    #1;
    checkOutput("pending_records", expQ.size(), 0);
    checkOutput("final_event_count", event_count, segRecords % 65536);
    checkOutput("final_busy", busy, 0);
    if (segRecords > 0) begin
      checkOutput("held_amplitude", peak_amplitude, lastRec.amp);
      checkOutput("held_time", peak_time, lastRec.tm);
    end
  endtask

  task automatic pushZeros(input int n);
    repeat (n) stim.push_back(0);
  endtask

  task automatic genRandom(input int nPulses);
    int len, r;
    stim.delete();
    for (int p = 0; p < nPulses; p++) begin
      repeat ($urandom_range(14, 1)) stim.push_back(int'($urandom_range(199, 0)));
      stim.push_back(int'($urandom_range(2000, THRESHOLD)));
      len = int'($urandom_range(75, 1));
      for (int q = 0; q < len; q++) begin
        r = int'($urandom_range(19, 0));
        if (r == 0) stim.push_back(65535);
        else if (r == 1) stim.push_back(int'($urandom_range(END_LEVEL - 1, 0)));
        else stim.push_back(int'($urandom_range(2200, END_LEVEL)));
      end
    end
    pushZeros(4);
  endtask

  always @(negedge clk) begin
    rec_t e;
    if (!reset && peak_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_record", 1, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("strobe_ts", tbTs, e.emitTs);
        checkOutput("amplitude", peak_amplitude, e.amp);
        checkOutput("peak_time", peak_time, e.tm);
        checkOutput("pileup", peak_pileup, e.pile);
        checkOutput("truncated", peak_truncated, e.trunc);
        checkOutput("event_count", event_count, e.cnt);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;

    stim.delete(); pushZeros(100);
    applyStimulus(0);

    stim.delete(); pushZeros(10);
    stim = {stim, 0, 100, 250, 400, 400, 300, 150, 50};
    pushZeros(4);
    applyStimulus(0);

    // Partial pulse, then a one-cycle reset landing on the 400 sample.
    filter_data = 16'd250;
    @(posedge clk); #1;
    stim.delete(); pushZeros(3);
    stim = {stim, 300, 500, 350, 420, 200, 100};
    pushZeros(12);
    stim = {stim, 300, 500, 350, 360, 200, 100};
    pushZeros(4);
    applyStimulus(400);

    stim.delete(); pushZeros(5);
    repeat (80) stim.push_back(1000);
    pushZeros(4);
    applyStimulus(0);

    stim.delete(); pushZeros(2);
    stim = {stim, 300, 400, 100, 0, 0, 300, 450, 100};
    pushZeros(4);
    applyStimulus(0);

    stim.delete(); pushZeros(2);
    repeat (5) stim.push_back(65535);
    pushZeros(4);
    applyStimulus(0);

    for (int s = 0; s < 6; s++) begin
      genRandom(12);
      applyStimulus(int'($urandom_range(1000, 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
